gps_spi_rx: RTL

//  Receive end of the GPS sample link. Accepts SCK/SS/MOSI from the CPLD

---
 rtl/gps_spi_rx_if.sv | 24 ++
 rtl/gps_spi_rx.sv | 112 +++++++++++
 2 files changed

// File: rtl/gps_spi_rx_if.sv
// gps_spi_rx_if: SPI pins and word-stream handshake of the GPS sample receiver
interface gps_spi_rx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic                  SPI_SCK;
  logic                  SPI_SS;
  logic                  SPI_MOSI;
  logic [DATA_WIDTH-1:0] WORD_DATA;
  logic                  WORD_VALID;
  logic                  WORD_READY;
  logic                  FRAME_ERR;
  logic                  OVERFLOW;
  logic                  CLR_OVF;
  logic [CNT_WIDTH-1:0]  WORD_COUNT;
  modport slave (
    input  SPI_SCK, SPI_SS, SPI_MOSI, WORD_READY, CLR_OVF,
    output WORD_DATA, WORD_VALID, FRAME_ERR, OVERFLOW, WORD_COUNT
  );
  modport master (
    output SPI_SCK, SPI_SS, SPI_MOSI, WORD_READY, CLR_OVF,
    input  WORD_DATA, WORD_VALID, FRAME_ERR, OVERFLOW, WORD_COUNT
  );
endinterface

// File: rtl/gps_spi_rx.sv
// gps_spi_rx: SPI slave deserialiser for the GPS sample link with output FIFO
module gps_spi_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input logic          MCU_CLK_25_000,
  input logic          RESET,
  gps_spi_rx_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t                r_state;
  logic [2:0]            r_sck_s;
  logic [2:0]            r_ss_s;
  logic [1:0]            r_mosi_s;
  logic [BW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_push;
  logic [DATA_WIDTH-1:0] r_push_data;
  logic                  r_fe;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]           r_wr;
  logic [AW:0]           r_rd;
  logic                  r_ovf;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  w_sck_rise;
  logic                  w_ss_fall;
  logic                  w_ss_rise;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_next;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_wr;
  logic                  w_drop;
  // SS synchroniser resets high so a slave select already low after reset opens a frame
  always_ff @(posedge MCU_CLK_25_000 or posedge RESET) begin
    if (RESET) begin
      r_sck_s  <= '0;
      r_ss_s   <= '1;
      r_mosi_s <= '0;
    end else begin
      r_sck_s  <= {r_sck_s[1:0], bus.SPI_SCK};
      r_ss_s   <= {r_ss_s[1:0], bus.SPI_SS};
      r_mosi_s <= {r_mosi_s[0], bus.SPI_MOSI};
    end
  end
  assign w_sck_rise = r_sck_s[1] & ~r_sck_s[2];
  assign w_ss_fall  = ~r_ss_s[1] & r_ss_s[2];
  assign w_ss_rise  = r_ss_s[1] & ~r_ss_s[2];
  assign w_last     = r_cnt == BW'(DATA_WIDTH - 1);
  assign w_next     = {r_shift[DATA_WIDTH-2:0], r_mosi_s[1]};
  // SS rise is checked before sck_rise so a coincident bit is dropped
  always_ff @(posedge MCU_CLK_25_000 or posedge RESET) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_push      <= 1'b0;
      r_push_data <= '0;
      r_fe        <= 1'b0;
    end else begin
      r_push <= 1'b0;
      r_fe   <= 1'b0;
      if (r_state == IDLE) begin
        if (w_ss_fall) begin
          r_state <= SHIFT;
          r_cnt   <= '0;
        end
      end else if (w_ss_rise) begin
        r_state <= IDLE;
        r_fe    <= r_cnt != '0;
        r_cnt   <= '0;
      end else if (w_sck_rise) begin
        r_shift <= w_next;
        r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
        if (w_last) begin
          r_push      <= 1'b1;
          r_push_data <= w_next;
        end
      end
    end
  end
  assign w_empty = r_wr == r_rd;
  assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop   = ~w_empty & bus.WORD_READY;
  assign w_wr    = r_push & (~w_full | w_pop);
  assign w_drop  = r_push & w_full & ~w_pop;
  always_ff @(posedge MCU_CLK_25_000) begin
    if (w_wr) r_mem[r_wr[AW-1:0]] <= r_push_data;
  end
  always_ff @(posedge MCU_CLK_25_000 or posedge RESET) begin
    if (RESET) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_ovf   <= 1'b0;
      r_count <= '0;
    end else begin
      r_wr    <= w_wr ? r_wr + 1'b1 : r_wr;
      r_rd    <= w_pop ? r_rd + 1'b1 : r_rd;
      r_count <= w_wr ? r_count + 1'b1 : r_count;
      r_ovf   <= w_drop | (r_ovf & ~bus.CLR_OVF);
    end
  end
  assign bus.WORD_VALID = ~w_empty;
  assign bus.WORD_DATA  = w_empty ? '0 : r_mem[r_rd[AW-1:0]];
  assign bus.FRAME_ERR  = r_fe;
  assign bus.OVERFLOW   = r_ovf;
  assign bus.WORD_COUNT = r_count;
endmodule
